// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   SPI-slave register bank. Every SPI pin is oversampled in the clk domain,
//   so nothing here is clocked by spi_clk. A frame is an ADDR_BITS address
//   field (MSB = mode) followed by a DATA_BITS data field, both sent MSB-first.
//   Mode 0 is set/clear (clear wins), mode 1 is a direct write. While the data
//   field arrives, the addressed register's pre-write value is shifted out on
//   dout. The write itself commits only when cs rises after a complete frame.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   spi_clk, cs, din  SPI mode 0 slave pins (cs active low)
//   special           bank select, active low; rising mid-frame aborts it
//   dout, dout_oe     readback bit and its enable (high while frame active)
//   reg_out           flat register image, index i at [i*REG_WIDTH +: REG_WIDTH]
//   wr_stb, wr_idx    one-clk pulse and register index of a committed write
//   frame_err         one-clk pulse on a short/long or aborted frame
module spi_reg_bank #(
    parameter int NREGS = 4,
    parameter int REG_WIDTH = 4,
    parameter int ADDR_BITS = 8,
    parameter int BASE_ADDR = 7,
    parameter logic [NREGS*REG_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       spi_clk,
    input  logic                                       cs,
    input  logic                                       special,
    input  logic                                       din,
    output logic                                       dout,
    output logic                                       dout_oe,
    output logic [NREGS*REG_WIDTH-1:0]                 reg_out,
    output logic                                       wr_stb,
    output logic [((NREGS > 1) ? $clog2(NREGS) : 1)-1:0] wr_idx,
    output logic                                       frame_err
);

    localparam int IDX_W      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int DATA_BITS  = 2 * REG_WIDTH;
    localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
    localparam int AL         = ADDR_BITS - 1;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    // Receive register must hold both the low address bits and the data field.
    localparam int RX_W       = (DATA_BITS > AL) ? DATA_BITS : AL;

    localparam logic [CNT_W-1:0] CNT_ADDR_M1 = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR    = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] CNT_FRAME   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(FRAME_BITS + 1);
    localparam logic [AL-1:0]    BASE_L      = AL'(BASE_ADDR);

    logic [2:0]             sclk_q, cs_q, sp_q;
    logic [1:0]             din_q;
    logic                   armed;
    logic [CNT_W-1:0]       cnt;
    logic [RX_W-1:0]        rx;
    logic [DATA_BITS-1:0]   tx;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [REG_WIDTH-1:0]   regs [NREGS];

    logic                   sclk_rise, sclk_fall, cs_s, cs_rise, sp_rise;
    logic                   active, start;
    logic [ADDR_BITS-1:0]   new_addr;
    logic [DATA_BITS-1:0]   load_val;
    logic [REG_WIDTH-1:0]   cur_val, next_val;
    logic [DATA_BITS-1:0]   val;
    logic                   commit_in_range;

    function automatic logic addr_in_range(input logic [AL-1:0] a);
        logic [31:0] au;
        au = 32'(a);
        return (au >= 32'(BASE_ADDR)) && (au < 32'(BASE_ADDR + NREGS));
    endfunction

    function automatic logic [AL-1:0] addr_index(input logic [AL-1:0] a);
        return a - BASE_L;
    endfunction

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_s      = cs_q[1];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign sp_rise   = sp_q[1] & ~sp_q[2];
    // A cs rise makes cs_s high, so it masks any spi_clk edge in that cycle.
    assign active    = ~cs_s & ~sp_q[1] & armed;
    assign start     = active & ~dout_oe;

    always_comb begin
        // Address as it will stand once the bit now being sampled is shifted in.
        new_addr        = {rx[AL-1:0], din_q[1]};
        load_val        = '0;
        cur_val         = '0;
        val             = rx[DATA_BITS-1:0];
        commit_in_range = addr_in_range(addr_q[AL-1:0]);
        for (int i = 0; i < NREGS; i++) begin
            if (addr_in_range(new_addr[AL-1:0]) && addr_index(new_addr[AL-1:0]) == AL'(i))
                load_val = {{REG_WIDTH{1'b0}}, regs[i]};
            if (addr_index(addr_q[AL-1:0]) == AL'(i))
                cur_val = regs[i];
        end
        if (addr_q[ADDR_BITS-1])
            next_val = val[REG_WIDTH-1:0];
        else
            next_val = (cur_val | val[REG_WIDTH-1:0]) & ~val[DATA_BITS-1:REG_WIDTH];
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NREGS; i++)
            reg_out[i*REG_WIDTH +: REG_WIDTH] = regs[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q    <= '0;
            cs_q      <= '0;
            sp_q      <= '0;
            din_q     <= '0;
            armed     <= 1'b0;
            dout_oe   <= 1'b0;
            dout      <= 1'b0;
            wr_stb    <= 1'b0;
            wr_idx    <= '0;
            frame_err <= 1'b0;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            addr_q    <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= RESET_VAL[i*REG_WIDTH +: REG_WIDTH];
        end else begin
            sclk_q    <= {sclk_q[1:0], spi_clk};
            cs_q      <= {cs_q[1:0], cs};
            sp_q      <= {sp_q[1:0], special};
            din_q     <= {din_q[0], din};
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            dout_oe   <= active;

            // Arming needs cs seen high, so a frame cut by reset or abort
            // cannot resume until the master deselects.
            if (cs_s)
                armed <= 1'b1;
            else if (sp_rise)
                armed <= 1'b0;

            if (start) begin
                cnt  <= '0;
                rx   <= '0;
                tx   <= '0;
                dout <= 1'b0;
            end else if (active) begin
                if (sclk_rise) begin
                    rx <= {rx[RX_W-2:0], din_q[1]};
                    if (cnt != CNT_MAX)
                        cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_ADDR_M1) begin
                        addr_q <= new_addr;
                        tx     <= load_val;
                    end
                end else if (sclk_fall && cnt >= CNT_ADDR) begin
                    dout <= tx[DATA_BITS-1];
                    tx   <= {tx[DATA_BITS-2:0], 1'b0};
                end
            end

            // dout_oe is last cycle's frame-active state.
            if (dout_oe) begin
                if (cs_rise) begin
                    if (cnt != CNT_FRAME) begin
                        frame_err <= 1'b1;
                    end else if (commit_in_range) begin
                        wr_stb <= 1'b1;
                        wr_idx <= IDX_W'(addr_index(addr_q[AL-1:0]));
                        for (int i = 0; i < NREGS; i++)
                            if (addr_index(addr_q[AL-1:0]) == AL'(i))
                                regs[i] <= next_val;
                    end
                end else if (sp_rise && !cs_s) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Testbench for spi_reg_bank at default parameters, clk = 8 x spi_clk.
// A register-image model plus a timed event queue predicts wr_stb, wr_idx,
// frame_err and reg_out every cycle; the driver checks readback bits and
// dout_oe, and literal values pin the model after each scenario.
module tb_spi_reg_bank;
    localparam int NREGS = 4;
    localparam int BASE  = 7;
    localparam logic [15:0] RST_IMG = 16'h0A50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_clk = 1'b0;
    logic        cs = 1'b1;
    logic        special = 1'b0;
    logic        din = 1'b0;
    logic        dout, dout_oe, wr_stb, frame_err;
    logic [15:0] reg_out;
    logic [1:0]  wr_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        bit         is_wr;
        bit         mode;
        int         idx;
        logic [7:0] data;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         ev;
    logic [15:0] img = RST_IMG;
    logic [7:0]  rb;

    spi_reg_bank #(
        .NREGS(4), .REG_WIDTH(4), .ADDR_BITS(8), .BASE_ADDR(7), .RESET_VAL(RST_IMG)
    ) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .cs(cs), .special(special),
        .din(din), .dout(dout), .dout_oe(dout_oe), .reg_out(reg_out),
        .wr_stb(wr_stb), .wr_idx(wr_idx), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit         e_stb;
        bit         e_err;
        int         e_idx;
        logic [3:0] old_v;
        e_stb = 0;
        e_err = 0;
        e_idx = 0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ev = exp_q.pop_front();
            if (ev.is_wr) begin
                old_v = img[ev.idx*4 +: 4];
                if (ev.mode)
                    img[ev.idx*4 +: 4] = ev.data[3:0];
                else
                    img[ev.idx*4 +: 4] = (old_v | ev.data[3:0]) & ~ev.data[7:4];
                e_stb = 1;
                e_idx = ev.idx;
            end else begin
                e_err = 1;
            end
        end
        chk("wr_stb", wr_stb, e_stb);
        chk("frame_err", frame_err, e_err);
        if (e_stb) chk("wr_idx", wr_idx, e_idx);
        chk("reg_out", reg_out, img);
    end

    // One SPI mode-0 frame, nbits sent MSB-first from f. abort_at / rst_at
    // give the bit index at which special rises / rst pulses (-1 = never).
    task automatic send_frame(input logic [15:0] f, input int nbits, input int abort_at,
                              input int rst_at, input bit exp_oe, output logic [7:0] rb_seen);
        int         addr;
        int         idx;
        bit         inr;
        bit         live;
        logic [7:0] rb_exp;
        ev_t        ev_n;
        addr   = int'(f[14:8]);
        inr    = (addr >= BASE) && (addr < BASE + NREGS);
        idx    = addr - BASE;
        rb_exp = 8'h00;
        if (inr) rb_exp = {4'h0, img[idx*4 +: 4]};
        live    = exp_oe;
        rb_seen = 8'h00;
        cs = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                img = RST_IMG;
                exp_q.delete();
                live = 0;
                wait_cyc(2);
                rst = 1'b0;
            end
            if (i == abort_at) begin
                special = 1'b1;
                if (live) begin
                    ev_n.cyc = cyc + 3; ev_n.is_wr = 0; ev_n.mode = 0; ev_n.idx = 0; ev_n.data = 8'h00;
                    exp_q.push_back(ev_n);
                end
                live = 0;
                wait_cyc(8);
                break;
            end
            din = f[nbits-1-i];
            wait_cyc(4);
            if (i == 4) chk("dout_oe_mid", dout_oe, exp_oe);
            if (live && i >= 8 && nbits == 16) begin
                rb_seen[15-i] = dout;
                chk("dout_bit", dout, rb_exp[15-i]);
            end
            spi_clk = 1'b1;
            wait_cyc(4);
            spi_clk = 1'b0;
        end
        wait_cyc(4);
        cs = 1'b1;
        if (live) begin
            ev_n.cyc = cyc + 3; ev_n.idx = 0; ev_n.mode = 0; ev_n.data = 8'h00; ev_n.is_wr = 0;
            if (nbits != 16) begin
                exp_q.push_back(ev_n);
            end else if (inr) begin
                ev_n.is_wr = 1; ev_n.mode = f[15]; ev_n.idx = idx; ev_n.data = f[7:0];
                exp_q.push_back(ev_n);
            end
        end
        wait_cyc(8);
        special = 1'b0;
        wait_cyc(4);
        chk("dout_oe_idle", dout_oe, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        wait_cyc(3);
        chk("rst_reg_out", reg_out, 16'h0A50);
        chk("rst_dout", dout, 1'b0);
        chk("rst_dout_oe", dout_oe, 1'b0);
        chk("rst_wr_stb", wr_stb, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_wr_idx", wr_idx, 2'd0);
        rst = 1'b0;
        wait_cyc(6);

        // Set/clear on index 1: (5 | 5) & ~3 = 4.
        send_frame(16'h0835, 16, -1, -1, 1'b1, rb);
        chk("rb_0835", rb, 8'h05);
        chk("img_0835", reg_out, 16'h0A40);

        // Direct write index 3 = C.
        send_frame(16'h8A0C, 16, -1, -1, 1'b1, rb);
        chk("rb_8A0C", rb, 8'h00);
        chk("img_8A0C", reg_out, 16'hCA40);

        // Index 3 readback C; set 3 and clear 3 together leaves C.
        send_frame(16'h0A33, 16, -1, -1, 1'b1, rb);
        chk("rb_0A33", rb, 8'h0C);
        chk("img_0A33", reg_out, 16'hCA40);

        // Set-only on index 2: A | 3 = B.
        send_frame(16'h0903, 16, -1, -1, 1'b1, rb);
        chk("rb_0903", rb, 8'h0A);
        chk("img_0903", reg_out, 16'hCB40);

        // Short frame: error, nothing written.
        send_frame(16'h0707, 15, -1, -1, 1'b1, rb);
        chk("img_short", reg_out, 16'hCB40);

        // Abort by special after 10 bits.
        send_frame(16'h0835, 16, 10, -1, 1'b1, rb);
        chk("img_abort", reg_out, 16'hCB40);

        // Out-of-range address: silently ignored.
        send_frame(16'h0301, 16, -1, -1, 1'b1, rb);
        chk("img_oor", reg_out, 16'hCB40);

        // special held high: frame ignored, dout_oe stays low.
        special = 1'b1;
        wait_cyc(4);
        send_frame(16'h8A00, 16, -1, -1, 1'b0, rb);
        chk("img_special_hi", reg_out, 16'hCB40);

        // Reset after 10 bits: image back to reset value, no commit.
        send_frame(16'h8A03, 16, -1, 10, 1'b1, rb);
        chk("img_rst_mid", reg_out, 16'h0A50);

        // Next full frame works: index 0 clear-all stays 0, strobe idx 0.
        send_frame(16'h07F0, 16, -1, -1, 1'b1, rb);
        chk("rb_07F0", rb, 8'h00);
        chk("img_07F0", reg_out, 16'h0A50);

        wait_cyc(10);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-slave register bank, successor to the fixed four-register bank on the SMU control FPGA. All SPI pins are oversampled in the system clock domain, so there is no logic clocked by the SPI clock. Each frame carries an address and a data field and performs one of two operations on one register of a parametrised bank:
- **set/clear**: clear wins over set;
- **direct write**.

During the data phase the slave shifts out the addressed register's pre-write value (readback). The block sits beside the CS/MISO muxes and drives the mux, LED, DAC and rails control bits.

## Interface
- `NREGS`, default 4: number of registers.
- `REG_WIDTH`, default 4: bits per register, range 1..16.
- `ADDR_BITS`, default 8: address field width. The MSB is the mode bit; the low `ADDR_BITS-1` bits are the address.
- `BASE_ADDR`, default 7: address of register index 0.
- `RESET_VAL`, default 0: flat `NREGS*REG_WIDTH` reset image; index i occupies bits `[i*REG_WIDTH +: REG_WIDTH]`.
- Derived: `DATA_BITS = 2*REG_WIDTH`; `FRAME_BITS = ADDR_BITS + DATA_BITS`, which is 16 at the defaults.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `spi_clk`, in, 1: SPI clock, mode 0, asynchronous to `clk`.
- `cs`, in, 1: chip select, active low.
- `special`, in, 1: bank select, active low.
- `din`, in, 1: MOSI, sent MSB-first.
- `dout`, out, 1: readback bit.
- `dout_oe`, out, 1: high while a frame is active; the external MISO mux uses this.
- `reg_out`, out, `NREGS*REG_WIDTH`: register contents, flat.
- `wr_stb`, out, 1: one-clk pulse on a committed write.
- `wr_idx`, out, `$clog2(NREGS)` (minimum 1 bit): index of the committed register, valid with `wr_stb`.
- `frame_err`, out, 1: one-clk pulse on a rejected frame.

## Operation
- **Input sync:** `spi_clk`, `cs`, `special` and `din` each pass through 2 flip-flops. A third flip-flop on `spi_clk`, `cs` and `special` supports edge and change detection. `din` is taken from the second stage.
- **Frame active:** `cs` low AND `special` low (synchronised) AND `armed`. The `armed` flag clears on reset and sets on the first cycle with synchronised `cs` high.
- **Frame start:** bit counter = 0, shift registers = 0, `dout` = 0.
- **Sampling:** on each synchronised `spi_clk` rising edge during an active frame, `din` shifts into the receive register LSB-first-in, moving toward the MSB.
- **Bit counter:** increments on each sampled bit and saturates at `FRAME_BITS+1`.
- **Address decode:** after the counter reaches `ADDR_BITS`:
  - mode = `addr[ADDR_BITS-1]`; index = `addr[ADDR_BITS-2:0] - BASE_ADDR`.
  - The address is in range when `BASE_ADDR <= addr[ADDR_BITS-2:0] < BASE_ADDR+NREGS`.
  - The addressed register's current value is loaded into the transmit register, zero-extended on the left to `DATA_BITS`. An out-of-range address loads 0.
- **Readback shift:** on each synchronised `spi_clk` falling edge with counter ≥ `ADDR_BITS`, `dout` takes the transmit register MSB and the register shifts left with zero fill. Before the first data bit, `dout` = 0.
- **Commit:** on the synchronised `cs` rising edge with the frame active, counter == `FRAME_BITS` and the address in range. With `val` = the low `DATA_BITS` of the receive register:
  - mode 0: `r <= (r | val[REG_WIDTH-1:0]) & ~val[DATA_BITS-1:REG_WIDTH]` (clear wins).
  - mode 1: `r <= val[REG_WIDTH-1:0]`; the upper half is ignored.
  - `wr_stb` pulses and `wr_idx` = index.
- **Reject:** pulse `frame_err`, modify no register and assert no `wr_stb` when either:
  - the `cs` rising edge arrives with counter != `FRAME_BITS`; or
  - `special` rises while `cs` is low, which aborts the frame immediately, drops the active state and stays inactive until `cs` goes high.
- **Out-of-range address:** silently ignored — no `wr_stb`, no `frame_err`.
- **Activity with `special` high:** ignored entirely; no counting, and `dout_oe` = 0.
- **`dout_oe`:** equals frame active (registered).

## Timing
- **Reset values:** `reg_out` = `RESET_VAL`; `dout`, `dout_oe`, `wr_stb`, `frame_err` and `wr_idx` = 0; `armed` = 0.
- **Reset mid-frame:** the frame is discarded; no activity is accepted until `cs` has been seen high.
- **Sync latency:** 2 clk cycles from the first `clk` edge that samples a pin change to the change being visible at the second stage.
- **Commit latency:** `reg_out`, `wr_stb` and `frame_err` update on the clk edge after the `cs` rise reaches the second stage, i.e. 2 clk edges after the first edge sampling `cs` high.
- **Readback latency:** `dout` changes 3 clk edges after the `spi_clk` falling edge. It is therefore valid for the master's next rising edge provided f(`spi_clk`) ≤ f(`clk`)/8.
- **Readback vs write:** readback returns the pre-write value; a write to the same register commits only at `cs` rise.
- **Simultaneous edges:** if a `cs` rise and a `spi_clk` edge are detected in the same cycle, the `cs` rise takes priority and the `spi_clk` edge is dropped.
- **Back-to-back frames:** `cs` high for ≥ 4 clk cycles between frames.

## Test plan
All scenarios use default parameters and `clk` = 8 × `spi_clk`.
- **Reset:** `RESET_VAL` = 0x0A50 → `reg_out` = 0x0A50; `dout`, `dout_oe`, `wr_stb` and `frame_err` all 0.
- **Set/clear:** frame 0x0835 (index 1 = 0x5) → index 1 = 0x4; `wr_stb` 1 cycle with `wr_idx` = 1; `dout` stream during data = 0000_0101.
- **Direct write:** frame 0x8A0C → index 3 = 0xC; the next frame addressing 0x0A reads back 0000_1100.
- **Short frame:** 15-bit frame 0x0707 → `frame_err` pulse, `reg_out` unchanged, no `wr_stb`.
- **Abort / out-of-range:** `special` rising after 10 bits → `frame_err` and no change. Frame 0x0301 → no change, no strobe, no error.
- **Reset mid-frame:** `rst` pulse after bit 9, then the remaining 6 bits and a `cs` rise → no commit. The next full frame 0x07F0 → index 0 = 0x0.
